// File: rtl/m_data_mem.sv
// m_data_mem: MEM-stage data memory with byte-lane stores and combinational extended loads
module m_data_mem #(
  parameter int          DEPTH = 3072,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  acc_type,
  output logic [31:0] rdata,
  output logic        addr_err
);
  localparam int IW = $clog2(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] off, rd_word, wr_word_d, wr_rep;
  logic [IW-1:0] idx;
  logic [3:0] be;
  logic is_word, is_half, is_byte, is_signed, in_range, misaligned, we;
  logic [15:0] half_sel;
  logic [7:0] byte_sel;
  always_comb begin
    off        = addr - BASE;
    idx        = off[IW+1:2];
    in_range   = (addr >= BASE) && (off < 32'(4 * DEPTH));
    is_word    = acc_type == 3'b000;
    is_half    = acc_type == 3'b001 || acc_type == 3'b010;
    is_byte    = acc_type == 3'b011 || acc_type == 3'b100;
    is_signed  = acc_type == 3'b001 || acc_type == 3'b011;
    misaligned = (is_word && addr[1:0] != 2'b00) || (is_half && addr[0]);
    addr_err   = (mem_read || mem_write) && (!in_range || misaligned || !(is_word || is_half || is_byte));
    we         = mem_write && !addr_err;
    rd_word    = in_range ? mem_q[idx] : '0;
    be         = is_word ? 4'b1111 : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr[1:0];
    wr_rep     = is_word ? wdata : is_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    for (int i = 0; i < 4; i++)
      wr_word_d[8*i +: 8] = be[i] ? wr_rep[8*i +: 8] : rd_word[8*i +: 8];
    half_sel   = addr[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel   = rd_word[8*addr[1:0] +: 8];
    rdata      = (!mem_read || addr_err) ? '0 :
                 is_word ? rd_word :
                 is_half ? {{16{is_signed & half_sel[15]}}, half_sel} :
                           {{24{is_signed & byte_sel[7]}}, byte_sel};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= wr_word_d;
    end
  end
endmodule

// File: doc/m_data_mem.md
Name: m_data_mem

Overview:
- Memory-stage data memory of the 5-stage MIPS pipeline. Sits between the E/M pipeline register and the M/W pipeline register.
- Performs sw/sh/sb stores and lw/lh/lhu/lb/lbu loads.
- Produces the extended load value, which the M/W register captures as M_dm on the next clk edge.
- Word-organised array with byte-lane write enables, synchronous write, combinational read.

Parameters:
- DEPTH, 3072, number of 32-bit words; legal byte addresses are BASE .. BASE+4*DEPTH-1.
- BASE, 32'h0000_0000, byte address of word 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears the whole array.
- addr  input  32  byte address from the M-stage ALU result.
- wdata  input  32  store data, already forwarded, from the M stage.
- mem_write  input  1  store request this cycle.
- mem_read  input  1  load request this cycle.
- acc_type  input  3  access type (encoding below).
- rdata  output  32  extended load data; combinational.
- addr_err  output  1  misaligned, out-of-range, or reserved-type access; combinational.

Behaviour:
- acc_type encoding:
  - 000: word.
  - 001: half, signed.
  - 010: half, unsigned.
  - 011: byte, signed.
  - 100: byte, unsigned.
  - 101-111: reserved.
- Stores ignore the signed/unsigned distinction.
- Address decode:
  - Word index = (addr-BASE)>>2.
  - Byte lane = addr[1:0].
  - Little-endian: lane 0 = bits 7:0, lane 3 = bits 31:24.
- addr_err = (mem_read|mem_write) AND any of:
  - addr < BASE, or addr >= BASE+4*DEPTH;
  - word access with addr[1:0]!=0;
  - half access with addr[0]!=0;
  - reserved acc_type.
- addr_err is 0 when neither mem_read nor mem_write is asserted.
- Store, on posedge clk when mem_write=1, reset=0, addr_err=0:
  - Word: whole word <= wdata.
  - Half: lanes {2*addr[1]+1, 2*addr[1]} <= wdata[15:0].
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Untouched lanes keep their value.
- A store with addr_err=1 changes no state.
- Load, combinational, when mem_read=1 and addr_err=0:
  - Word: the word.
  - Half: the selected half, sign- or zero-extended to 32.
  - Byte: the selected byte, sign- or zero-extended to 32.
- rdata = 0 when mem_read=0 or addr_err=1.
- Read/write same cycle, same address: rdata shows pre-write contents; the new value is visible from the cycle after the edge.
- mem_read and mem_write both high: the store is performed and rdata shows old contents. This is legal and is not an error.
- Reset:
  - On posedge with reset=1, every word <= 0 and any store that cycle is discarded.
  - Reset asserted mid-sequence wipes data written earlier.
  - There are no registered outputs; rdata and addr_err follow inputs and array contents immediately, so after reset rdata=0 for any in-range load.
- Latency: store commits at the edge closing the cycle; load data is valid within the same cycle for capture by the M/W register.
- The array is the only state; there is no internal FSM. The sequential element is the byte-enabled array write.

Test Plan:
- Reset, then lw at 0x0, 0x4, 0x2FFC -> rdata=0x00000000, addr_err=0.
- sw 0x12345678 @0x10; then lw @0x10 -> 0x12345678. lbu @0x10 -> 0x78. lbu @0x13 -> 0x12. lhu @0x12 -> 0x1234.
- sw 0x0 @0x20; sb 0xAB @0x21; sh 0x80FF @0x22; then:
  - lw @0x20 -> 0x80FFAB00.
  - lb @0x21 -> 0xFFFFFFAB.
  - lh @0x22 -> 0xFFFF80FF.
  - lhu @0x22 -> 0x000080FF.
- Misaligned and out-of-range stores change nothing:
  - sw @0x31 -> addr_err=1; then lw @0x30 is unchanged.
  - sh @0x33 -> addr_err=1.
  - lw @0x3000 (DEPTH=3072) -> addr_err=1, rdata=0.
  - acc_type=111 with mem_read -> addr_err=1.
- Same cycle sw 0xDEADBEEF @0x40 with mem_read @0x40 -> rdata shows old value 0. Next cycle lw @0x40 -> 0xDEADBEEF.
- sw 0x55 @0x50; then reset and sw 0x77 @0x54 in the same cycle; then lw @0x50 and lw @0x54 -> both 0 (store discarded, array cleared).
